// File: rtl/load_pkg.sv
// Load-type codes and width constant for the load path.
// The decoder, datamem and load unit all use these definitions.
// The optional misalignment check is enabled with the LOAD_MISALIGN_CHK_EN macro.
package load_pkg;

    // Data and address width. Only 32 is supported.
    localparam int XLEN = 32;

    // Load-type codes carried on info_load. Codes 6 and 7 are reserved.
    localparam logic [2:0] LD_NONE = 3'd0;
    localparam logic [2:0] LB      = 3'd1;
    localparam logic [2:0] LH      = 3'd2;
    localparam logic [2:0] LW      = 3'd3;
    localparam logic [2:0] LBU     = 3'd4;
    localparam logic [2:0] LHU     = 3'd5;

    // True for the two byte-sized load types.
    function automatic logic is_byte_load(input logic [2:0] info);
        return (info == LB) || (info == LBU);
    endfunction

    // True for the two halfword-sized load types.
    function automatic logic is_half_load(input logic [2:0] info);
        return (info == LH) || (info == LHU);
    endfunction

    // True for load types that sign-extend their result.
    function automatic logic is_signed_load(input logic [2:0] info);
        return (info == LB) || (info == LH);
    endfunction

    // An access is misaligned when a halfword starts on an odd byte or a
    // word does not start on a word boundary. Byte loads never misalign.
    // Reserved codes and LD_NONE do not access memory, so they never
    // report a misalignment.
    function automatic logic is_misaligned(input logic [2:0] info,
                                           input logic [1:0] rem);
        return (is_half_load(info) && rem[0]) ||
               ((info == LW) && (rem != 2'd0));
    endfunction

endpackage : load_pkg

// File: rtl/load_extract.sv
// Combinational lane select and sign/zero extension for loads.
// Bytes are numbered little-endian within the word: lane n is bits [8n+7:8n].
// A halfword starting at lane 3 does not wrap into the next word; its high
// byte reads as zero.
module load_extract
    import load_pkg::*;
(
    input  logic [2:0]      info_load,
    input  logic [XLEN-1:0] addr_data,
    input  logic [1:0]      addr_rem,
    output logic [XLEN-1:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Pick the addressed byte and the halfword that starts at that byte.
    always_comb begin
        // NOTE: every output of an always_comb gets a value before any branch,
        // so no path can leave it unassigned and infer a latch.
        byte_lane = 8'h00;
        half_lane = 16'h0000;
        unique case (addr_rem)
            2'd0: begin
                byte_lane = addr_data[7:0];
                half_lane = addr_data[15:0];
            end
            2'd1: begin
                byte_lane = addr_data[15:8];
                half_lane = addr_data[23:8];
            end
            2'd2: begin
                byte_lane = addr_data[23:16];
                half_lane = addr_data[31:16];
            end
            2'd3: begin
                byte_lane = addr_data[31:24];
                half_lane = {8'h00, addr_data[31:24]};
            end
            default: begin
                byte_lane = 8'h00;
                half_lane = 16'h0000;
            end
        endcase
    end

    // Extend the selected lane to the full width according to the load type.
    always_comb begin
        data = '0;
        if (is_byte_load(info_load)) begin
            if (is_signed_load(info_load)) begin
                data = {{(XLEN-8){byte_lane[7]}}, byte_lane};
            end else begin
                data = {{(XLEN-8){1'b0}}, byte_lane};
            end
        end else if (is_half_load(info_load)) begin
            if (is_signed_load(info_load)) begin
                data = {{(XLEN-16){half_lane[15]}}, half_lane};
            end else begin
                data = {{(XLEN-16){1'b0}}, half_lane};
            end
        end else if (info_load == LW) begin
            data = addr_data;
        end
    end

endmodule : load_extract

// File: rtl/load_unit.sv
// Load alignment/extension stage with a one-cycle registered output.
// Every cycle is accepted. When in_valid is low, data and addr_q hold their
// previous values and out_valid drops.
// Optional feature: define LOAD_MISALIGN_CHK_EN to add the registered
// misalign flag.
module load_unit
    import load_pkg::*;
#(
    parameter int XLEN = load_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [2:0]      info_load,
    input  logic [XLEN-1:0] addr_data,
    input  logic [1:0]      addr_rem,
    input  logic [XLEN-1:0] alu_result,
`ifdef LOAD_MISALIGN_CHK_EN
    output logic            misalign,
`endif
    output logic [XLEN-1:0] data,
    output logic            out_valid,
    output logic [XLEN-1:0] addr_q
);

    logic [XLEN-1:0] extracted;

    load_extract u_extract (
        .info_load (info_load),
        .addr_data (addr_data),
        .addr_rem  (addr_rem),
        .data      (extracted)
    );

    // Output register stage. Reset takes priority over a request in the same cycle.
    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments, so every register
        // samples values from before the edge regardless of statement order.
        if (!rst_n) begin
            data      <= '0;
            addr_q    <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                data   <= extracted;
                addr_q <= alu_result;
            end
        end
    end

`ifdef LOAD_MISALIGN_CHK_EN
    // Misalignment flag. It is cleared on idle cycles, so it is only
    // asserted alongside out_valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            misalign <= 1'b0;
        end else begin
            misalign <= in_valid && is_misaligned(info_load, addr_rem);
        end
    end
`endif

endmodule : load_unit

// File: tb/tb_load_unit.sv
// Self-checking bench for load_unit: directed vectors with literal
// expectations, plus a random sweep compared against a behavioural model.
// Build with LOAD_MISALIGN_CHK_EN defined to also cover the misalign output.
module tb_load_unit;
    import load_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [2:0]  info_load = 3'd0;
    logic [31:0] addr_data = 32'h0;
    logic [1:0]  addr_rem = 2'd0;
    logic [31:0] alu_result = 32'h0;
    logic [31:0] data;
    logic        out_valid;
    logic [31:0] addr_q;
`ifdef LOAD_MISALIGN_CHK_EN
    logic        misalign;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    load_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .info_load  (info_load),
        .addr_data  (addr_data),
        .addr_rem   (addr_rem),
        .alu_result (alu_result),
`ifdef LOAD_MISALIGN_CHK_EN
        .misalign   (misalign),
`endif
        .data       (data),
        .out_valid  (out_valid),
        .addr_q     (addr_q)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result: shift the addressed byte down to bit 0, then keep
    // 8 or 16 bits. Bytes shifted in from above the word read as zero.
    function automatic logic [31:0] ref_load(input logic [2:0] t,
                                             input logic [31:0] w,
                                             input logic [1:0] r);
        logic [31:0] sh;
        sh = w >> (8 * int'(r));
        case (t)
            3'd1: return 32'($signed(sh[7:0]));
            3'd4: return {24'h0, sh[7:0]};
            3'd2: return 32'($signed(sh[15:0]));
            3'd5: return {16'h0, sh[15:0]};
            3'd3: return w;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic ref_misalign(input logic [2:0] t, input logic [1:0] r);
        if (t == 3'd2 || t == 3'd5) return (r % 2) != 0;
        if (t == 3'd3) return r != 0;
        return 1'b0;
    endfunction

    // Behavioural model of the output stage.
    logic [31:0] m_data = 32'h0;
    logic [31:0] m_addr = 32'h0;
    logic        m_valid = 1'b0;
    logic        m_mis = 1'b0;
    logic        m_ready = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_data  <= 32'h0;
            m_addr  <= 32'h0;
            m_valid <= 1'b0;
            m_mis   <= 1'b0;
            m_ready <= 1'b1;
        end else begin
            m_valid <= in_valid;
            m_mis   <= in_valid && ref_misalign(info_load, addr_rem);
            if (in_valid) begin
                m_data <= ref_load(info_load, addr_data, addr_rem);
                m_addr <= alu_result;
            end
        end
    end

    // Compare every cycle once the model has seen a reset.
    always @(negedge clk) begin
        if (m_ready) begin
            check("model_valid", {31'h0, out_valid}, {31'h0, m_valid});
            check("model_data", data, m_data);
            check("model_addr", addr_q, m_addr);
`ifdef LOAD_MISALIGN_CHK_EN
            check("model_misalign", {31'h0, misalign}, {31'h0, m_mis});
`endif
        end
    end

    // Drive one cycle of inputs at the falling edge, then wait past the rising edge.
    task automatic apply(input logic v, input logic [2:0] t, input logic [31:0] w,
                         input logic [1:0] r, input logic [31:0] a);
        @(negedge clk);
        in_valid   = v;
        info_load  = t;
        addr_data  = w;
        addr_rem   = r;
        alu_result = a;
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] WORD = 32'h80F1_7F82;

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_data", data, 32'h0);
        check("reset_valid", {31'h0, out_valid}, 32'h0);
        check("reset_addr", addr_q, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        apply(1'b1, LB, WORD, 2'd0, 32'h0000_1000);
        check("lb_rem0", data, 32'hFFFF_FF82);
        check("lb_rem0_valid", {31'h0, out_valid}, 32'h1);
        check("lb_rem0_addr", addr_q, 32'h0000_1000);
        apply(1'b1, LBU, WORD, 2'd1, 32'h0000_1001);
        check("lbu_rem1", data, 32'h0000_007F);
        apply(1'b1, LBU, WORD, 2'd3, 32'h0000_1003);
        check("lbu_rem3", data, 32'h0000_0080);
        apply(1'b1, LB, WORD, 2'd3, 32'h0000_1003);
        check("lb_rem3", data, 32'hFFFF_FF80);
        apply(1'b1, LH, WORD, 2'd2, 32'h0000_1002);
        check("lh_rem2", data, 32'hFFFF_80F1);
        apply(1'b1, LHU, WORD, 2'd0, 32'h0000_1000);
        check("lhu_rem0", data, 32'h0000_7F82);
        apply(1'b1, LH, WORD, 2'd3, 32'h0000_1003);
        check("lh_rem3", data, 32'h0000_0080);
        apply(1'b1, LHU, WORD, 2'd1, 32'h0000_1001);
        check("lhu_rem1", data, 32'h0000_F17F);
`ifdef LOAD_MISALIGN_CHK_EN
        check("lhu_rem1_mis", {31'h0, misalign}, 32'h1);
`endif
        apply(1'b1, LW, WORD, 2'd0, 32'h0000_1000);
        check("lw_rem0", data, 32'h80F1_7F82);
`ifdef LOAD_MISALIGN_CHK_EN
        check("lw_rem0_mis", {31'h0, misalign}, 32'h0);
`endif
        apply(1'b1, LW, WORD, 2'd2, 32'h0000_1002);
        check("lw_rem2", data, 32'h80F1_7F82);
`ifdef LOAD_MISALIGN_CHK_EN
        check("lw_rem2_mis", {31'h0, misalign}, 32'h1);
`endif
        apply(1'b1, 3'd6, WORD, 2'd0, 32'h0000_2000);
        check("rsvd6", data, 32'h0);
        apply(1'b1, LD_NONE, WORD, 2'd1, 32'h0000_2001);
        check("ld_none", data, 32'h0);
        apply(1'b1, LW, 32'hDEAD_BEEF, 2'd0, 32'h0000_3000);
        apply(1'b0, LB, 32'h1234_5678, 2'd1, 32'h0000_4000);
        check("idle_valid", {31'h0, out_valid}, 32'h0);
        check("idle_data_hold", data, 32'hDEAD_BEEF);
        check("idle_addr_hold", addr_q, 32'h0000_3000);
`ifdef LOAD_MISALIGN_CHK_EN
        check("idle_mis", {31'h0, misalign}, 32'h0);
`endif

        // Reset overrides a simultaneous request.
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b1;
        info_load = LW;
        addr_data = WORD;
        addr_rem = 2'd2;
        alu_result = 32'h0000_5002;
        @(posedge clk);
        #1;
        check("rst_req_data", data, 32'h0);
        check("rst_req_valid", {31'h0, out_valid}, 32'h0);
        check("rst_req_addr", addr_q, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Random sweep, checked by the model comparator.
        for (int i = 0; i < 1000; i++) begin
            apply($urandom_range(3, 0) != 0, 3'($urandom_range(7, 0)), $urandom,
                  2'($urandom_range(3, 0)), $urandom);
        end
        apply(1'b0, LD_NONE, 32'h0, 2'd0, 32'h0);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_load_unit
